int_ctrl: RTL and testbench

Interrupt controller sitting between the periodic timer and other board interrupt sources and the 5-stage pipeline CPU. It registers level-sensitive requests, applies per-source masking and a global enable, and presents one prioritised request with its source id to the CPU. It completes the request/acknowledge handshake back to the source (timer_int_ack for the timer), and blocks further requests until the handler signals return.

---
 rtl/int_ctrl_pkg.sv | 19 +
 rtl/int_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 147 ++++++++++++++
 tb/tb_int_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and register map for the interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 2;
  localparam int unsigned CAUSE_VALID_BIT = 31;

  localparam logic [ADDR_W-1:0] ADDR_MASK  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PEND  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_GIE   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CAUSE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder; index 0 (timer) has top priority.
module int_prio_enc #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_any_c,
  output logic [ID_W-1:0]    o_id_c
);

  always_comb begin
    o_any_c = 1'b0;
    o_id_c  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_req[i] && !o_any_c) begin
        o_any_c = 1'b1;
        o_id_c  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: registered level requests, mask/GIE, single prioritised
// request to the CPU with taken/done handshake and per-source ack pulse.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] i_src_int,
  output logic [NUM_SRC-1:0] o_src_ack,
  input  logic               i_cfg_we,
  input  logic [ADDR_W-1:0]  i_cfg_addr,
  input  logic [DATA_W-1:0]  i_cfg_wdata,
  output logic [DATA_W-1:0]  o_cfg_rdata,
  output logic               o_irq_req,
  output logic [ID_W-1:0]    o_irq_id,
  input  logic               i_irq_taken,
  input  logic               i_irq_done
);

  state_e              r_state;
  state_e              w_next_state;
  logic [NUM_SRC-1:0]  r_pending;
  logic [NUM_SRC-1:0]  r_mask;
  logic                r_gie;
  logic                r_irq_req;
  logic [ID_W-1:0]     r_irq_id;
  logic [NUM_SRC-1:0]  r_src_ack;
  logic [DATA_W-1:0]   r_cfg_rdata;

  logic [NUM_SRC-1:0]  w_eligible;
  logic                w_any;
  logic [ID_W-1:0]     w_win_id;
  logic                w_wr_mask;
  logic                w_wr_gie;
  logic                w_gie_clr;
  logic                w_latch_id;
  logic                w_ack_fire;
  logic [NUM_SRC-1:0]  w_ack_vec;
  logic [DATA_W-1:0]   w_cause;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused_ok;

  assign w_unused_ok = &{1'b0, i_cfg_wdata};

  assign w_wr_mask  = i_cfg_we && (i_cfg_addr == ADDR_MASK);
  assign w_wr_gie   = i_cfg_we && (i_cfg_addr == ADDR_GIE);
  assign w_gie_clr  = w_wr_gie && !i_cfg_wdata[0];
  assign w_eligible = r_pending & r_mask;
  assign w_ack_vec  = NUM_SRC'(1) << r_irq_id;

  int_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .i_req   (w_eligible),
    .o_any_c (w_any),
    .o_id_c  (w_win_id)
  );

  // Request sampling and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_gie     <= 1'b0;
    end else begin
      r_pending <= i_src_int;
      if (w_wr_mask) r_mask <= i_cfg_wdata[NUM_SRC-1:0];
      if (w_wr_gie)  r_gie  <= i_cfg_wdata[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state; a GIE clear only withdraws a request when taken is absent.
  always_comb begin
    w_next_state = r_state;
    w_latch_id   = 1'b0;
    w_ack_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_gie && w_any) begin
          w_next_state = ST_REQ;
          w_latch_id   = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_irq_taken) begin
          w_next_state = ST_SERVICE;
          w_ack_fire   = 1'b1;
        end else if (w_gie_clr || !r_gie) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (i_irq_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs, registered off the next-state decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_req <= 1'b0;
      r_irq_id  <= '0;
      r_src_ack <= '0;
    end else begin
      r_irq_req <= (w_next_state == ST_REQ);
      if (w_latch_id) r_irq_id <= w_win_id;
      r_src_ack <= w_ack_fire ? w_ack_vec : '0;
    end
  end

  always_comb begin
    w_cause                  = '0;
    w_cause[CAUSE_VALID_BIT] = (r_state == ST_SERVICE);
    w_cause[ID_W-1:0]        = r_irq_id;
  end

  always_comb begin
    w_rdata = '0;
    case (i_cfg_addr)
      ADDR_MASK:  w_rdata = DATA_W'(r_mask);
      ADDR_PEND:  w_rdata = DATA_W'(r_pending);
      ADDR_GIE:   w_rdata = DATA_W'(r_gie);
      ADDR_CAUSE: w_rdata = w_cause;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cfg_rdata <= '0;
    else       r_cfg_rdata <= w_rdata;
  end

  assign o_irq_req   = r_irq_req;
  assign o_irq_id    = r_irq_id;
  assign o_src_ack   = r_src_ack;
  assign o_cfg_rdata = r_cfg_rdata;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_int_ctrl;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ID_W    = 2;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] src_ack;
  logic               we;
  logic [1:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               taken;
  logic               done;

  int n_vec;
  int n_err;
  int ack_cnt [NUM_SRC];

  // Reference model state
  logic [3:0]  m_pending, m_mask, m_ack;
  logic        m_gie, m_req, m_svc;
  int          m_id;
  logic [31:0] m_rdata;

  int_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_src_int   (src),
    .o_src_ack   (src_ack),
    .i_cfg_we    (we),
    .i_cfg_addr  (addr),
    .i_cfg_wdata (wdata),
    .o_cfg_rdata (rdata),
    .o_irq_req   (irq_req),
    .o_irq_id    (irq_id),
    .i_irq_taken (taken),
    .i_irq_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pending = '0; m_mask = '0; m_gie = 1'b0;
    m_req = 1'b0; m_svc = 1'b0; m_id = 0; m_ack = '0; m_rdata = '0;
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic tick();
    logic [3:0] elig;
    logic       gie_clr;
    @(posedge clk);
    case (addr)
      2'd0:    m_rdata = {28'd0, m_mask};
      2'd1:    m_rdata = {28'd0, m_pending};
      2'd2:    m_rdata = {31'd0, m_gie};
      default: m_rdata = (m_svc ? 32'h8000_0000 : 32'h0) | 32'(m_id);
    endcase
    gie_clr = we && (addr == 2'd2) && !wdata[0];
    m_ack = '0;
    if (m_req) begin
      if (taken) begin
        m_ack = 4'(1 << m_id);
        m_req = 1'b0;
        m_svc = 1'b1;
      end else if (gie_clr || !m_gie) begin
        m_req = 1'b0;
      end
    end else if (m_svc) begin
      if (done) m_svc = 1'b0;
    end else begin
      elig = m_pending & m_mask;
      if (m_gie && elig != 0) begin
        m_id  = lowest(elig);
        m_req = 1'b1;
      end
    end
    if (we && addr == 2'd0) m_mask = wdata[3:0];
    if (we && addr == 2'd2) m_gie  = wdata[0];
    m_pending = src;
    #1;
    chk("irq_req", 32'(irq_req), 32'(m_req));
    chk("irq_id",  32'(irq_id),  32'(m_id));
    chk("src_ack", 32'(src_ack), 32'(m_ack));
    chk("rdata",   rdata,        m_rdata);
    for (int i = 0; i < NUM_SRC; i++) ack_cnt[i] += int'(src_ack[i]);
    src = src & ~m_ack;  // source releases its line once acked
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 8; k++) begin
      if (irq_req) break;
      tick();
    end
    chk("wait_req", 32'(irq_req), 32'd1);
  endtask

  task automatic serve(input int exp_id, input string tag);
    wait_req();
    chk(tag, 32'(irq_id), 32'(exp_id));
    taken = 1'b1; tick(); taken = 1'b0;
    tick();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_req",   32'(irq_req), 32'd0);
    chk("rst_id",    32'(irq_id),  32'd0);
    chk("rst_ack",   32'(src_ack), 32'd0);
    chk("rst_rdata", rdata,        32'd0);
    model_reset();
    taken = 1'b0; done = 1'b0; we = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; src = '0; we = 1'b0; addr = '0; wdata = '0;
    taken = 1'b0; done = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) ack_cnt[i] = 0;
    model_reset();
    #1;
    chk("por_req",   32'(irq_req), 32'd0);
    chk("por_ack",   32'(src_ack), 32'd0);
    chk("por_rdata", rdata,        32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Timer basic
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h1);
    src = 4'b0001;
    tick(); chk("timer_lat1", 32'(irq_req), 32'd0);
    tick(); chk("timer_lat2", 32'(irq_req), 32'd1);
    chk("timer_id", 32'(irq_id), 32'd0);
    taken = 1'b1; tick(); taken = 1'b0;
    chk("timer_ack", 32'(src_ack), 32'h1);
    addr = 2'd3; tick();
    chk("cause_svc", rdata, 32'h8000_0000);
    done = 1'b1; tick(); done = 1'b0;
    tick(); chk("cause_idle", rdata, 32'h0);

    // Priority
    wr(2'd0, 32'hF);
    for (int i = 0; i < NUM_SRC; i++) ack_cnt[i] = 0;
    src = 4'b1010;
    serve(1, "prio_first");
    serve(3, "prio_second");
    tick(); tick();
    chk("acks_src0", 32'(ack_cnt[0]), 32'd0);
    chk("acks_src1", 32'(ack_cnt[1]), 32'd1);
    chk("acks_src3", 32'(ack_cnt[3]), 32'd1);

    // Masking
    wr(2'd0, 32'hE);
    src = 4'b0001;
    tick(); tick(); tick();
    chk("masked_noreq", 32'(irq_req), 32'd0);
    addr = 2'd1; tick();
    chk("pend_read", rdata, 32'h1);
    wr(2'd0, 32'hF);
    chk("unmask_lat1", 32'(irq_req), 32'd0);
    tick();
    chk("unmask_lat2", 32'(irq_req), 32'd1);
    serve(0, "unmask_id");

    // Withdraw, then taken racing a GIE clear
    src = 4'b0100;
    wait_req();
    wr(2'd2, 32'h0);
    chk("wd_req", 32'(irq_req), 32'd0);
    chk("wd_ack", 32'(src_ack), 32'd0);
    tick(); tick();
    chk("wd_stay", 32'(irq_req), 32'd0);
    wr(2'd2, 32'h1);
    wait_req();
    chk("race_id", 32'(irq_id), 32'd2);
    we = 1'b1; addr = 2'd2; wdata = 32'h0; taken = 1'b1;
    tick();
    we = 1'b0; taken = 1'b0;
    chk("race_ack", 32'(src_ack), 32'h4);
    addr = 2'd3; tick();
    chk("race_cause", rdata, 32'h8000_0002);
    done = 1'b1; tick(); done = 1'b0;
    wr(2'd2, 32'h1);

    // No nesting, stray done/taken
    src = 4'b0010;
    wait_req();
    taken = 1'b1; tick(); taken = 1'b0;
    src[0] = 1'b1;
    repeat (4) tick();
    chk("nonest", 32'(irq_req), 32'd0);
    done = 1'b1; tick(); done = 1'b0;
    chk("nonest_done", 32'(irq_req), 32'd0);
    tick();
    chk("nonest_next", 32'(irq_req), 32'd1);
    chk("nonest_id", 32'(irq_id), 32'd0);
    taken = 1'b1; tick(); taken = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    taken = 1'b1; tick(); taken = 1'b0;
    chk("stray_ack", 32'(src_ack), 32'd0);

    // Async reset in REQ and in SERVICE
    src = 4'b1000;
    wait_req();
    do_reset();
    addr = 2'd0; tick(); chk("rst_mask", rdata, 32'd0);
    addr = 2'd2; tick(); chk("rst_gie", rdata, 32'd0);
    wr(2'd0, 32'hF);
    wr(2'd2, 32'h1);
    wait_req();
    taken = 1'b1; tick(); taken = 1'b0;
    do_reset();
    tick();

    // Random traffic
    wr(2'd0, 32'hF);
    wr(2'd2, 32'h1);
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (!src[i] && ($urandom % 10) == 0) src[i] = 1'b1;
      taken = m_req ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
      done  = m_svc ? (($urandom % 4) == 0) : (($urandom % 20) == 0);
      we    = (($urandom % 12) == 0);
      addr  = 2'($urandom % 4);
      wdata = $urandom;
      if (addr == 2'd2) wdata[0] = (($urandom % 4) != 0);
      tick();
      taken = 1'b0; done = 1'b0; we = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
